clct_win_sequencer: RTL and testbench
=====================================

CLCT_WIN_SEQUENCER -- requirements
Module: clct_win_sequencer

Interface
REQ-001 Parameter BLANK, default 1: windows within +/-BLANK of the first-pass best are zeroed for the second pass (legal range 0..7).
REQ-002 Parameter PRI_THRESH, default 1: minimum priority for a result to be flagged valid (legal range 1..15).
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request; win_pri_in is valid in the same cycle.
REQ-006 win_pri_in  input  64  16 window priorities; window i occupies bits [4i+3:4i].
REQ-007 enc_pri  output  64  registered priority vector driving the external 16-window tree encoder; same packing as win_pri_in.
REQ-008 enc_win_best  input  4  combinational best-window index returned by the encoder.
REQ-009 enc_pri_best  input  4  combinational best priority returned by the encoder.
REQ-010 busy  output  1  high while a request is in progress.
REQ-011 done  output  1  one-cycle pulse; result outputs are valid in this cycle.
REQ-012 win_1st, pri_1st  output  4 each  first-pass window and priority.
REQ-013 vld_1st  output  1  first-pass result meets PRI_THRESH.
REQ-014 win_2nd, pri_2nd  output  4 each  second-pass window and priority.
REQ-015 vld_2nd  output  1  second-pass result is valid.
REQ-016 start_drop  output  1  one-cycle pulse flagging a rejected start.

Function
REQ-017 The FSM SHALL have states IDLE, PASS1, PASS2 and DONE.
REQ-018 In IDLE or DONE, start=1 SHALL load enc_pri with win_pri_in and move to PASS1; otherwise IDLE stays IDLE and DONE returns to IDLE.
REQ-019 In PASS1 the block SHALL capture enc_win_best and enc_pri_best into internal first-result registers.
REQ-020 In PASS1 the block SHALL load enc_pri with the masked vector and move to PASS2.
REQ-021 Masked vector: window i SHALL be zeroed when |i - enc_win_best| <= BLANK, clamped to 0..15 with no wrap-around; all other windows unchanged.
REQ-022 In PASS2 the block SHALL copy the first-result registers and the current encoder outputs to win_1st/pri_1st and win_2nd/pri_2nd in one edge, then move to DONE.
REQ-023 vld_1st SHALL equal (pri_1st >= PRI_THRESH).
REQ-024 vld_2nd SHALL equal (pri_2nd >= PRI_THRESH) AND vld_1st.
REQ-025 busy SHALL be 1 in PASS1, PASS2 and DONE, and 0 in IDLE.
REQ-026 done SHALL be 1 only in DONE; latency is start at cycle T -> done at T+3.
REQ-027 Result outputs SHALL hold from DONE until the next PASS2->DONE edge, i.e. they are stable across any intervening request.
REQ-028 start in PASS1 or PASS2 SHALL be ignored, with start_drop=1 for exactly the following cycle; state and results are unaffected.
REQ-029 start in DONE SHALL be accepted, giving back-to-back throughput of one request per 3 cycles, with done asserted on every third cycle.
REQ-030 Tie-breaking SHALL be inherited unchanged from the encoder; the controller never reorders windows.
REQ-031 The second pass SHALL always execute, even when vld_1st=0.

Reset
REQ-032 reset=1 SHALL force IDLE, with enc_pri, all result outputs, busy, done and start_drop set to 0.
REQ-033 reset SHALL take priority over start in the same cycle.
REQ-034 reset during PASS1, PASS2 or DONE SHALL abort the request; no done pulse follows.

Verification (bench instantiates the team's 16-window tree encoder on enc_pri)
REQ-035 Reset then 10 idle cycles -> all outputs 0, busy=0, enc_pri=0.
REQ-036 win5=9, win12=7, others 0, BLANK=1, start at T -> done at T+3; win_1st=5, pri_1st=9, vld_1st=1; win_2nd=12, pri_2nd=7, vld_2nd=1.
REQ-037 win5=9, win6=8, win9=3 -> win_1st=5/9; window 6 is blanked, so win_2nd=9, pri_2nd=3.
REQ-038 win0=15, win1=14, win15=2, BLANK=1 -> win_1st=0/15, win_2nd=15/2 (no wrap masking); all-zero input -> win_1st=0/0, win_2nd=0/0, vld_1st=0, vld_2nd=0.
REQ-039 Back-to-back starts at T and T+3 -> done at T+3 and T+6 with independent results; start at T+1 -> start_drop at T+2, and the T+3 result is unchanged.
REQ-040 reset asserted at T+2 of a request -> no done pulse, outputs 0 at T+3, and a new start is accepted normally afterwards.

Source files
------------

// File: rtl/clct_win_sequencer.sv
// rtl/clct_win_sequencer.sv - two-pass best/second-best window sequencer around an external tree encoder
// Pass 1 finds the best window, pass 2 re-encodes with +/-BLANK neighbours zeroed.
module clct_win_sequencer #(
   parameter int BLANK      = 1,
   parameter int PRI_THRESH = 1
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [63:0] i_win_pri_in,
   output logic [63:0] o_enc_pri,
   input  logic [3:0]  i_enc_win_best,
   input  logic [3:0]  i_enc_pri_best,
   output logic        o_busy,
   output logic        o_done,
   output logic [3:0]  o_win_1st,
   output logic [3:0]  o_pri_1st,
   output logic        o_vld_1st,
   output logic [3:0]  o_win_2nd,
   output logic [3:0]  o_pri_2nd,
   output logic        o_vld_2nd,
   output logic        o_start_drop
);

   localparam logic [3:0] LP_BLANK  = 4'(BLANK);
   localparam logic [3:0] LP_THRESH = 4'(PRI_THRESH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PASS1 = 2'd1,
      ST_PASS2 = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        w_load_in;
   logic        w_load_mask;
   logic        w_commit;
   logic        w_drop;

   logic [63:0] r_enc_pri;
   logic [63:0] w_masked;
   logic [3:0]  r_win_first;
   logic [3:0]  r_pri_first;
   logic        w_vld_1st;
   logic        w_vld_2nd;

   logic [3:0]  r_win_1st;
   logic [3:0]  r_pri_1st;
   logic        r_vld_1st;
   logic [3:0]  r_win_2nd;
   logic [3:0]  r_pri_2nd;
   logic        r_vld_2nd;
   logic        r_start_drop;

   // Distance is taken on plain indices 0..15, so blanking clamps at the ends instead of wrapping.
   function automatic logic win_blanked(input logic [3:0] idx, input logic [3:0] best);
      logic [3:0] d;
      d = (idx >= best) ? (idx - best) : (best - idx);
      return (d <= LP_BLANK);
   endfunction

   always_comb begin
      w_masked = r_enc_pri;
      for (int i = 0; i < 16; i++) begin
         if (win_blanked(4'(i), i_enc_win_best)) begin
            w_masked[4*i +: 4] = 4'h0;
         end
      end
   end

   always_comb begin
      w_next      = r_state;
      w_load_in   = 1'b0;
      w_load_mask = 1'b0;
      w_commit    = 1'b0;
      w_drop      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_next    = ST_PASS1;
               w_load_in = 1'b1;
            end
         end
         ST_PASS1: begin
            w_next      = ST_PASS2;
            w_load_mask = 1'b1;
            w_drop      = i_start;
         end
         ST_PASS2: begin
            w_next   = ST_DONE;
            w_commit = 1'b1;
            w_drop   = i_start;
         end
         ST_DONE: begin
            if (i_start) begin
               w_next    = ST_PASS1;
               w_load_in = 1'b1;
            end else begin
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   assign w_vld_1st = (r_pri_first >= LP_THRESH);
   assign w_vld_2nd = (i_enc_pri_best >= LP_THRESH) && w_vld_1st;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_enc_pri    <= 64'h0;
         r_win_first  <= 4'h0;
         r_pri_first  <= 4'h0;
         r_win_1st    <= 4'h0;
         r_pri_1st    <= 4'h0;
         r_vld_1st    <= 1'b0;
         r_win_2nd    <= 4'h0;
         r_pri_2nd    <= 4'h0;
         r_vld_2nd    <= 1'b0;
         r_start_drop <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_start_drop <= w_drop;
         if (w_load_in) begin
            r_enc_pri <= i_win_pri_in;
         end else if (w_load_mask) begin
            r_enc_pri <= w_masked;
         end
         if (w_load_mask) begin
            r_win_first <= i_enc_win_best;
            r_pri_first <= i_enc_pri_best;
         end
         // Results only change here, so they stay stable across the next request's passes.
         if (w_commit) begin
            r_win_1st <= r_win_first;
            r_pri_1st <= r_pri_first;
            r_vld_1st <= w_vld_1st;
            r_win_2nd <= i_enc_win_best;
            r_pri_2nd <= i_enc_pri_best;
            r_vld_2nd <= w_vld_2nd;
         end
      end
   end

   assign o_enc_pri    = r_enc_pri;
   assign o_busy       = (r_state != ST_IDLE);
   assign o_done       = (r_state == ST_DONE);
   assign o_win_1st    = r_win_1st;
   assign o_pri_1st    = r_pri_1st;
   assign o_vld_1st    = r_vld_1st;
   assign o_win_2nd    = r_win_2nd;
   assign o_pri_2nd    = r_pri_2nd;
   assign o_vld_2nd    = r_vld_2nd;
   assign o_start_drop = r_start_drop;

endmodule

// File: tb/tb_clct_win_sequencer.sv
// tb/tb_clct_win_sequencer.sv - self-checking bench for clct_win_sequencer
// Includes a behavioural 16-window encoder (highest priority, lowest index on ties).
module tb_clct_win_sequencer;

   localparam int BLANK      = 1;
   localparam int PRI_THRESH = 1;

   logic        clk;
   logic        i_reset;
   logic        i_start;
   logic [63:0] i_win_pri_in;
   logic [63:0] o_enc_pri;
   logic [3:0]  w_enc_win;
   logic [3:0]  w_enc_pri;
   logic        o_busy;
   logic        o_done;
   logic [3:0]  o_win_1st;
   logic [3:0]  o_pri_1st;
   logic        o_vld_1st;
   logic [3:0]  o_win_2nd;
   logic [3:0]  o_pri_2nd;
   logic        o_vld_2nd;
   logic        o_start_drop;
   logic [17:0] w_obs;

   int          checks;
   int          failures;
   logic [17:0] sb[$];

   clct_win_sequencer #(.BLANK(BLANK), .PRI_THRESH(PRI_THRESH)) dut (
      .i_clock        (clk),
      .i_reset        (i_reset),
      .i_start        (i_start),
      .i_win_pri_in   (i_win_pri_in),
      .o_enc_pri      (o_enc_pri),
      .i_enc_win_best (w_enc_win),
      .i_enc_pri_best (w_enc_pri),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_win_1st      (o_win_1st),
      .o_pri_1st      (o_pri_1st),
      .o_vld_1st      (o_vld_1st),
      .o_win_2nd      (o_win_2nd),
      .o_pri_2nd      (o_pri_2nd),
      .o_vld_2nd      (o_vld_2nd),
      .o_start_drop   (o_start_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] enc_best(input logic [63:0] v);
      logic [3:0] bw;
      logic [3:0] bp;
      bw = 4'd0;
      bp = v[3:0];
      for (int i = 1; i < 16; i++) begin
         if (v[4*i +: 4] > bp) begin
            bp = v[4*i +: 4];
            bw = 4'(i);
         end
      end
      return {bw, bp};
   endfunction

   assign {w_enc_win, w_enc_pri} = enc_best(o_enc_pri);
   assign w_obs = {o_win_1st, o_pri_1st, o_vld_1st, o_win_2nd, o_pri_2nd, o_vld_2nd};

   function automatic logic [17:0] model(input logic [63:0] v);
      logic [7:0]  b1;
      logic [7:0]  b2;
      logic [63:0] m;
      logic        v1;
      logic        v2;
      int          d;
      b1 = enc_best(v);
      m  = v;
      for (int i = 0; i < 16; i++) begin
         d = i - int'(b1[7:4]);
         if (d < 0) d = -d;
         if (d <= BLANK) m[4*i +: 4] = 4'h0;
      end
      b2 = enc_best(m);
      v1 = (int'(b1[3:0]) >= PRI_THRESH);
      v2 = (int'(b2[3:0]) >= PRI_THRESH) && v1;
      return {b1[7:4], b1[3:0], v1, b2[7:4], b2[3:0], v2};
   endfunction

   function automatic logic [63:0] pv(input int w, input int p);
      logic [63:0] v;
      v = 64'h0;
      v[4*w +: 4] = 4'(p);
      return v;
   endfunction

   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         i_start = 1'b0;
         lat++;
      end while (!o_done && lat < 20);
   endtask

   task automatic run_one(input logic [63:0] v, input logic [17:0] exp, output int lat,
                          output logic [17:0] obs, output logic [17:0] want);
      i_win_pri_in = v;
      i_start      = 1'b1;
      sb.push_back(exp);
      wait_done(lat);
      obs  = w_obs;
      want = (sb.size() > 0) ? sb.pop_front() : 18'h3ffff;
   endtask

   task automatic test_reset;
      i_reset      = 1'b1;
      i_start      = 1'b1;
      i_win_pri_in = pv(4, 9);
      repeat (3) @(negedge clk);
      checks++;
      if (o_busy !== 1'b0 || o_enc_pri !== 64'h0) begin
         failures++;
         $display("FAIL reset_over_start: busy=%b enc_pri=%h required busy=0 enc_pri=0", o_busy, o_enc_pri);
      end
      i_start = 1'b0;
      i_reset = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (w_obs !== 18'h0) begin
         failures++;
         $display("FAIL reset_results: got=%h required=0", w_obs);
      end
      checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_start_drop !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags: busy=%b done=%b drop=%b required 0 0 0", o_busy, o_done, o_start_drop);
      end
      checks++;
      if (o_enc_pri !== 64'h0) begin
         failures++;
         $display("FAIL reset_enc_pri: got=%h required=0", o_enc_pri);
      end
   endtask

   task automatic test_single_pass;
      int          lat;
      logic [17:0] obs;
      logic [17:0] want;
      run_one(pv(5, 9) | pv(12, 7), {4'd5, 4'd9, 1'b1, 4'd12, 4'd7, 1'b1}, lat, obs, want);
      checks++;
      if (lat !== 3 || o_done !== 1'b1) begin
         failures++;
         $display("FAIL basic_latency: got=%0d done=%b required=3", lat, o_done);
      end
      checks++;
      if (obs !== want) begin
         failures++;
         $display("FAIL basic_result: got=%h required=%h", obs, want);
      end
      @(negedge clk);
      checks++;
      if (o_done !== 1'b0 || o_busy !== 1'b0 || w_obs !== want) begin
         failures++;
         $display("FAIL basic_after_done: done=%b busy=%b res=%h required 0 0 %h", o_done, o_busy, w_obs, want);
      end
   endtask

   task automatic test_blank_adjacent;
      int          lat;
      logic [17:0] obs;
      logic [17:0] want;
      run_one(pv(5, 9) | pv(6, 8) | pv(9, 3), {4'd5, 4'd9, 1'b1, 4'd9, 4'd3, 1'b1}, lat, obs, want);
      checks++;
      if (lat !== 3 || obs !== want) begin
         failures++;
         $display("FAIL blank_adjacent: lat=%0d got=%h required lat=3 res=%h", lat, obs, want);
      end
   endtask

   task automatic test_edges;
      int          lat;
      logic [17:0] obs;
      logic [17:0] want;
      run_one(pv(0, 15) | pv(1, 14) | pv(15, 2), {4'd0, 4'd15, 1'b1, 4'd15, 4'd2, 1'b1}, lat, obs, want);
      checks++;
      if (lat !== 3 || obs !== want) begin
         failures++;
         $display("FAIL edge_no_wrap: lat=%0d got=%h required lat=3 res=%h", lat, obs, want);
      end
      @(negedge clk);
      run_one(64'h0, 18'h0, lat, obs, want);
      checks++;
      if (lat !== 3 || obs !== want) begin
         failures++;
         $display("FAIL edge_all_zero: lat=%0d got=%h required lat=3 res=%h", lat, obs, want);
      end
   endtask

   task automatic test_back_to_back;
      logic [63:0] va;
      logic [63:0] vb;
      logic [17:0] ea;
      logic [17:0] eb;
      logic [17:0] want;
      va = pv(2, 6) | pv(10, 11);
      vb = pv(7, 4) | pv(8, 4) | pv(14, 1);
      ea = {4'd10, 4'd11, 1'b1, 4'd2, 4'd6, 1'b1};
      eb = {4'd7, 4'd4, 1'b1, 4'd14, 4'd1, 1'b1};
      @(negedge clk);
      i_win_pri_in = va;
      i_start      = 1'b1;
      sb.push_back(ea);
      @(negedge clk);
      i_win_pri_in = 64'hffff_ffff_ffff_ffff;
      i_start      = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      checks++;
      if (o_start_drop !== 1'b1 || o_done !== 1'b0) begin
         failures++;
         $display("FAIL b2b_drop: drop=%b done=%b required 1 0", o_start_drop, o_done);
      end
      @(negedge clk);
      want = (sb.size() > 0) ? sb.pop_front() : 18'h3ffff;
      checks++;
      if (o_done !== 1'b1 || w_obs !== want || o_start_drop !== 1'b0) begin
         failures++;
         $display("FAIL b2b_first: done=%b drop=%b got=%h required 1 0 %h", o_done, o_start_drop, w_obs, want);
      end
      i_win_pri_in = vb;
      i_start      = 1'b1;
      sb.push_back(eb);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         i_start = 1'b0;
         checks++;
         if (o_done !== 1'b0 || o_busy !== 1'b1 || w_obs !== ea) begin
            failures++;
            $display("FAIL b2b_hold: done=%b busy=%b got=%h required 0 1 %h", o_done, o_busy, w_obs, ea);
         end
      end
      @(negedge clk);
      want = (sb.size() > 0) ? sb.pop_front() : 18'h3ffff;
      checks++;
      if (o_done !== 1'b1 || w_obs !== want) begin
         failures++;
         $display("FAIL b2b_second: done=%b got=%h required 1 %h", o_done, w_obs, want);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_abort;
      int          lat;
      int          extra_done;
      logic [17:0] obs;
      logic [17:0] want;
      i_win_pri_in = pv(3, 5) | pv(11, 13);
      i_start      = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      @(negedge clk);
      i_reset = 1'b1;
      @(negedge clk);
      i_reset = 1'b0;
      checks++;
      if (o_done !== 1'b0 || o_busy !== 1'b0 || w_obs !== 18'h0) begin
         failures++;
         $display("FAIL abort_state: done=%b busy=%b res=%h required 0 0 0", o_done, o_busy, w_obs);
      end
      extra_done = 0;
      repeat (4) begin
         @(negedge clk);
         if (o_done) extra_done++;
      end
      checks++;
      if (extra_done !== 0) begin
         failures++;
         $display("FAIL abort_no_done: got=%0d done pulses required=0", extra_done);
      end
      run_one(pv(8, 12) | pv(9, 12) | pv(13, 6), {4'd8, 4'd12, 1'b1, 4'd13, 4'd6, 1'b1}, lat, obs, want);
      checks++;
      if (lat !== 3 || obs !== want) begin
         failures++;
         $display("FAIL abort_restart: lat=%0d got=%h required lat=3 res=%h", lat, obs, want);
      end
   endtask

   task automatic test_random;
      int          lat;
      logic [17:0] obs;
      logic [17:0] want;
      logic [63:0] v;
      for (int n = 0; n < 8; n++) begin
         v = 64'h0;
         for (int w = 0; w < 16; w++) begin
            if ($urandom_range(0, 3) == 0) v[4*w +: 4] = 4'($urandom_range(1, 15));
         end
         @(negedge clk);
         run_one(v, model(v), lat, obs, want);
         checks++;
         if (lat !== 3 || obs !== want) begin
            failures++;
            $display("FAIL random_%0d: vec=%h lat=%0d got=%h required lat=3 res=%h", n, v, lat, obs, want);
         end
      end
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      i_reset      = 1'b1;
      i_start      = 1'b0;
      i_win_pri_in = 64'h0;
      @(negedge clk);
      test_reset();
      test_single_pass();
      test_blank_adjacent();
      test_edges();
      test_back_to_back();
      test_reset_abort();
      test_random();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got=%0d entries required=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
